// File: rtl/sseg_mux_decoder.sv
// Passive monitor for a multiplexed active-low 7-segment bus: filters, decodes and stores each digit.
// Define SSEG_DEC_SYNC_EN to put 2-FF synchronisers on an_i/sseg_i when the bus is asynchronous.
module sseg_mux_decoder #(
   parameter int N_DIGITS      = 4,
   parameter int STABLE_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_DIGITS-1:0]   an_i,
   input  logic [6:0]            sseg_i,
   input  logic                  clr_i,
   output logic [4*N_DIGITS-1:0] digits_o,
   output logic [N_DIGITS-1:0]   digit_valid_o,
   output logic                  frame_done_o,
   output logic                  code_err_o,
   output logic                  an_err_o
);

   localparam int SW = N_DIGITS + 7;
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   // Returns {hit, value}; labels are written in a..g order, so the bus is bit-reversed first.
   function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
      logic [4:0] res;
      case ({seg[0], seg[1], seg[2], seg[3], seg[4], seg[5], seg[6]})
         7'b0000001: res = {1'b1, 4'h0};
         7'b1001111: res = {1'b1, 4'h1};
         7'b0010010: res = {1'b1, 4'h2};
         7'b0000110: res = {1'b1, 4'h3};
         7'b1001100: res = {1'b1, 4'h4};
         7'b0100100: res = {1'b1, 4'h5};
         7'b0100000: res = {1'b1, 4'h6};
         7'b0001111: res = {1'b1, 4'h7};
         7'b0000000: res = {1'b1, 4'h8};
         7'b0000100: res = {1'b1, 4'h9};
         7'b0001000: res = {1'b1, 4'hA};
         7'b1100000: res = {1'b1, 4'hB};
         7'b0110001: res = {1'b1, 4'hC};
         7'b1000010: res = {1'b1, 4'hD};
         7'b0110000: res = {1'b1, 4'hE};
         7'b0111000: res = {1'b1, 4'hF};
         default:    res = {1'b0, 4'h0};
      endcase
      return res;
   endfunction

   logic [SW-1:0] sample_s;

`ifdef SSEG_DEC_SYNC_EN
   logic [SW-1:0] sync1_q;
   logic [SW-1:0] sync2_q;

   // Synchronisers idle at all ones so a reset looks like display blanking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= {SW{1'b1}};
         sync2_q <= {SW{1'b1}};
      end else begin
         sync1_q <= {an_i, sseg_i};
         sync2_q <= sync1_q;
      end
   end

   assign sample_s = sync2_q;
`else
   assign sample_s = {an_i, sseg_i};
`endif

   logic [SW-1:0]         prev_q, prev_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0] digits_q, digits_d;
   logic [N_DIGITS-1:0]   valid_q, valid_d;
   logic [N_DIGITS-1:0]   mask_q, mask_d;
   logic                  frame_q, frame_d;
   logic                  code_err_q, code_err_d;
   logic                  an_err_q, an_err_d;
   logic                  accept_s;
   logic [N_DIGITS-1:0]   an_s;
   logic [N_DIGITS-1:0]   mask_new_s;
   logic [6:0]            glyph_s;
   logic [4:0]            dec_s;

   assign an_s    = sample_s[SW-1:7];
   assign glyph_s = sample_s[6:0];
   assign dec_s   = decode_glyph(glyph_s);

   always_comb begin
      prev_d     = sample_s;
      cnt_d      = cnt_q;
      accept_s   = 1'b0;
      digits_d   = digits_q;
      valid_d    = valid_q;
      mask_d     = mask_q;
      frame_d    = 1'b0;
      code_err_d = code_err_q;
      an_err_d   = an_err_q;
      mask_new_s = mask_q | ~an_s;

      // Accept fires once, on the sample that takes the counter to saturation.
      if (sample_s != prev_q) begin
         cnt_d = {CW{1'b0}};
      end else if (cnt_q != CNT_MAX) begin
         cnt_d    = cnt_q + CW'(1);
         accept_s = (cnt_q == CNT_LAST);
      end else begin
         cnt_d = cnt_q;
      end

      if (clr_i) begin
         prev_d     = {SW{1'b1}};
         cnt_d      = {CW{1'b0}};
         digits_d   = {(4*N_DIGITS){1'b0}};
         valid_d    = {N_DIGITS{1'b0}};
         mask_d     = {N_DIGITS{1'b0}};
         code_err_d = 1'b0;
         an_err_d   = 1'b0;
      end else if (accept_s) begin
         if (&an_s) begin
            frame_d = 1'b0;
         end else if ($onehot(~an_s)) begin
            for (int k = 0; k < N_DIGITS; k++) begin
               if (!an_s[k]) begin
                  if (dec_s[4]) begin
                     digits_d[4*k +: 4] = dec_s[3:0];
                     valid_d[k]         = 1'b1;
                  end else if (glyph_s == 7'b1111111) begin
                     digits_d[4*k +: 4] = 4'h0;
                     valid_d[k]         = 1'b0;
                  end else begin
                     code_err_d = 1'b1;
                  end
               end else begin
                  valid_d[k] = valid_q[k];
               end
            end
            if (&mask_new_s) begin
               frame_d = 1'b1;
               mask_d  = {N_DIGITS{1'b0}};
            end else begin
               mask_d = mask_new_s;
            end
         end else begin
            an_err_d = 1'b1;
         end
      end else begin
         frame_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q     <= {SW{1'b1}};
         cnt_q      <= {CW{1'b0}};
         digits_q   <= {(4*N_DIGITS){1'b0}};
         valid_q    <= {N_DIGITS{1'b0}};
         mask_q     <= {N_DIGITS{1'b0}};
         frame_q    <= 1'b0;
         code_err_q <= 1'b0;
         an_err_q   <= 1'b0;
      end else begin
         prev_q     <= prev_d;
         cnt_q      <= cnt_d;
         digits_q   <= digits_d;
         valid_q    <= valid_d;
         mask_q     <= mask_d;
         frame_q    <= frame_d;
         code_err_q <= code_err_d;
         an_err_q   <= an_err_d;
      end
   end

   assign digits_o      = digits_q;
   assign digit_valid_o = valid_q;
   assign frame_done_o  = frame_q;
   assign code_err_o    = code_err_q;
   assign an_err_o      = an_err_q;

endmodule
